// File: rtl/issue_scoreboard.sv
// Issue controller for the pipelined core: holds or issues the fetch instruction
// against a pending-write scoreboard and squashes issue on a taken branch.
module issue_scoreboard #(
    parameter int MAX_PENDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        validF,
    input  logic [3:0]  rs1F,
    input  logic [3:0]  rs2F,
    input  logic        useRs1F,
    input  logic        useRs2F,
    input  logic [3:0]  rdF,
    input  logic        wrRdF,
    input  logic        isBranchTakenE,
    input  logic        wbValid,
    input  logic [3:0]  wbRd,
    output logic        stallF,
    output logic        flushF,
    output logic        issueE,
    output logic [3:0]  rdE,
    output logic [15:0] busy,
    output logic [3:0]  pendCount,
    output logic        wbErr
);

    // Handshake: validF offers an instruction; it is consumed in the cycle where
    // issue is high (valid, not stalled, not flushed); otherwise fetch holds or drops it.
    localparam logic [3:0] MAX_P = 4'(MAX_PENDING);

    logic [15:0] busy_q, busy_d;
    logic [3:0]  pend_count_q, pend_count_d;
    logic        issue_e_q, issue_e_d;
    logic [3:0]  rd_e_q, rd_e_d;
    logic        wb_err_q, wb_err_d;

    logic [15:0] wb_onehot;
    logic [15:0] eff_busy;
    logic        src_haz, waw_haz, cap_haz;
    logic        issue, set_en, clr_en;

    always_comb begin
        wb_onehot = '0;
        if (wbValid) wb_onehot[wbRd] = 1'b1;
        // A register completing writeback this cycle no longer blocks readers.
        eff_busy = busy_q & ~wb_onehot;

        src_haz = (useRs1F && rs1F != 4'd0 && eff_busy[rs1F]) ||
                  (useRs2F && rs2F != 4'd0 && eff_busy[rs2F]);
        waw_haz = wrRdF && rdF != 4'd0 && eff_busy[rdF];
        cap_haz = wrRdF && rdF != 4'd0 && pend_count_q == MAX_P;

        stallF = validF && !isBranchTakenE && (src_haz || waw_haz || cap_haz);
        flushF = isBranchTakenE;
        issue  = validF && !stallF && !isBranchTakenE;

        set_en = issue && wrRdF && rdF != 4'd0;
        clr_en = wbValid && wbRd != 4'd0 && busy_q[wbRd];
    end

    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[wbRd] = 1'b0;
        // Applied after the clear so a same-register set wins.
        if (set_en) busy_d[rdF] = 1'b1;
        busy_d[0] = 1'b0;

        pend_count_d = pend_count_q;
        if (set_en && !clr_en)      pend_count_d = pend_count_q + 4'd1;
        else if (clr_en && !set_en) pend_count_d = pend_count_q - 4'd1;

        issue_e_d = issue;
        rd_e_d    = (issue && wrRdF) ? rdF : 4'd0;
        wb_err_d  = wb_err_q || (wbValid && wbRd != 4'd0 && !busy_q[wbRd]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q       <= '0;
            pend_count_q <= '0;
            issue_e_q    <= 1'b0;
            rd_e_q       <= '0;
            wb_err_q     <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            pend_count_q <= pend_count_d;
            issue_e_q    <= issue_e_d;
            rd_e_q       <= rd_e_d;
            wb_err_q     <= wb_err_d;
        end
    end

    assign issueE    = issue_e_q;
    assign rdE       = rd_e_q;
    assign busy      = busy_q;
    assign pendCount = pend_count_q;
    assign wbErr     = wb_err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: driver pushes expected rdE per issue,
// a negedge monitor pops on issueE; direct checks cover hazards and scoreboard state.
module tb_issue_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        validF;
    logic [3:0]  rs1F, rs2F;
    logic        useRs1F, useRs2F;
    logic [3:0]  rdF;
    logic        wrRdF;
    logic        isBranchTakenE;
    logic        wbValid;
    logic [3:0]  wbRd;
    logic        stallF, flushF, issueE;
    logic [3:0]  rdE;
    logic [15:0] busy;
    logic [3:0]  pendCount;
    logic        wbErr;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    issue_scoreboard #(.MAX_PENDING(4)) dut (
        .clk(clk), .reset(reset), .validF(validF),
        .rs1F(rs1F), .rs2F(rs2F), .useRs1F(useRs1F), .useRs2F(useRs2F),
        .rdF(rdF), .wrRdF(wrRdF), .isBranchTakenE(isBranchTakenE),
        .wbValid(wbValid), .wbRd(wbRd),
        .stallF(stallF), .flushF(flushF), .issueE(issueE), .rdE(rdE),
        .busy(busy), .pendCount(pendCount), .wbErr(wbErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        validF = 0; rs1F = 0; rs2F = 0; useRs1F = 0; useRs2F = 0;
        rdF = 0; wrRdF = 0; isBranchTakenE = 0; wbValid = 0; wbRd = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Monitor: every registered issue must match the oldest expected destination.
    initial begin
        forever begin
            @(negedge clk);
            if (issueE === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected: got issueE=1 rdE=%0d expected no issue", rdE);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    if (rdE !== e) begin
                        errors++;
                        $display("FAIL issue_rdE: got %0d expected %0d", rdE, e);
                    end
                end
            end
        end
    end

    initial begin
        idle();
        reset = 1;
        cycle();
        cycle();
        reset = 0;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_pend", 32'(pendCount), 0);
        chk("rst_issueE", 32'(issueE), 0);
        chk("rst_rdE", 32'(rdE), 0);
        chk("rst_wbErr", 32'(wbErr), 0);

        // Issue r3 write.
        validF = 1; wrRdF = 1; rdF = 3;
        settle();
        chk("t1_stall", 32'(stallF), 0);
        exp_q.push_back(4'd3);
        cycle();
        chk("t1_busy", 32'(busy), 32'h0008);
        chk("t1_pend", 32'(pendCount), 1);

        // RAW on r3 until writeback bypass.
        idle();
        validF = 1; useRs1F = 1; rs1F = 3;
        settle();
        chk("t2_stall_a", 32'(stallF), 1);
        cycle();
        chk("t2_stall_b", 32'(stallF), 1);
        chk("t2_no_issue", 32'(issueE), 0);
        wbValid = 1; wbRd = 3;
        settle();
        chk("t2_bypass", 32'(stallF), 0);
        exp_q.push_back(4'd0);
        cycle();
        idle();
        chk("t2_busy", 32'(busy), 32'h0);
        chk("t2_pend", 32'(pendCount), 0);

        // Fill all four slots.
        for (int i = 1; i <= 4; i++) begin
            idle();
            validF = 1; wrRdF = 1; rdF = 4'(i);
            settle();
            chk("t3_fill_stall", 32'(stallF), 0);
            exp_q.push_back(4'(i));
            cycle();
        end
        idle();
        chk("t3_busy_full", 32'(busy), 32'h001E);
        chk("t3_pend_full", 32'(pendCount), 4);
        validF = 1; wrRdF = 1; rdF = 5;
        settle();
        chk("t3_cap_stall", 32'(stallF), 1);
        wbValid = 1; wbRd = 2;
        settle();
        chk("t3_cap_wb_stall", 32'(stallF), 1);
        cycle();
        wbValid = 0; wbRd = 0;
        settle();
        chk("t3_pend_freed", 32'(pendCount), 3);
        chk("t3_cap_release", 32'(stallF), 0);
        exp_q.push_back(4'd5);
        cycle();
        idle();
        chk("t3_busy_after", 32'(busy), 32'h003A);
        chk("t3_pend_after", 32'(pendCount), 4);

        // Branch squashes a RAW-stalled instruction.
        validF = 1; useRs1F = 1; rs1F = 4;
        settle();
        chk("t4_raw_stall", 32'(stallF), 1);
        chk("t4_no_flush", 32'(flushF), 0);
        isBranchTakenE = 1;
        settle();
        chk("t4_flush", 32'(flushF), 1);
        chk("t4_stall_forced", 32'(stallF), 0);
        cycle();
        idle();
        chk("t4_issueE", 32'(issueE), 0);
        chk("t4_busy", 32'(busy), 32'h003A);

        // Free a slot, then issue r5 alongside its own writeback.
        wbValid = 1; wbRd = 1;
        cycle();
        idle();
        chk("t5_pre_busy", 32'(busy), 32'h0038);
        chk("t5_pre_pend", 32'(pendCount), 3);
        validF = 1; wrRdF = 1; rdF = 5; wbValid = 1; wbRd = 5;
        settle();
        chk("t5_stall", 32'(stallF), 0);
        exp_q.push_back(4'd5);
        cycle();
        idle();
        chk("t5_busy", 32'(busy), 32'h0038);
        chk("t5_pend", 32'(pendCount), 3);
        chk("t5_wbErr", 32'(wbErr), 0);

        // Spurious writeback raises sticky error.
        wbValid = 1; wbRd = 7;
        cycle();
        idle();
        chk("t6_wbErr_set", 32'(wbErr), 1);
        chk("t6_busy_kept", 32'(busy), 32'h0038);
        cycle();
        cycle();
        chk("t6_wbErr_sticky", 32'(wbErr), 1);

        // Reset drops pending writes; r0 writeback is harmless, stale r3 is not.
        reset = 1;
        cycle();
        reset = 0;
        chk("t7_rst_wbErr", 32'(wbErr), 0);
        chk("t7_rst_busy", 32'(busy), 32'h0);
        chk("t7_rst_pend", 32'(pendCount), 0);
        wbValid = 1; wbRd = 0;
        cycle();
        idle();
        chk("t7_wb_r0", 32'(wbErr), 0);
        wbValid = 1; wbRd = 3;
        cycle();
        idle();
        chk("t7_wb_stale", 32'(wbErr), 1);
        chk("t7_pend_stale", 32'(pendCount), 0);

        cycle();
        cycle();
        chk("exp_q_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
